// File: rtl/mux_scan_n.sv
// mux_scan_n: CH-channel, W-bit registered selector with a valid/ready output.
// Direct mode selects a loaded channel; scan mode walks the channels with a dwell.
// Optional macro MUX_SCAN_MASK_EN adds the ch_mask_i per-channel scan enable.

module mux_scan_n #(
    parameter int unsigned CH    = 8,
    parameter int unsigned W     = 1,
    parameter int unsigned DWELL = 1,
    localparam int unsigned SELW = $clog2(CH)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CH*W-1:0]     in_i,
    input  logic [SELW-1:0]     sel_i,
    input  logic                load_i,
    input  logic                mode_i,
`ifdef MUX_SCAN_MASK_EN
    input  logic [CH-1:0]       ch_mask_i,
`endif
    input  logic                out_ready_i,
    output logic [W-1:0]        out_o,
    output logic [SELW-1:0]     out_ch_o,
    output logic                out_valid_o,
    output logic                wrap_o,
    output logic                err_o
);

    localparam int unsigned CNTW = $clog2(DWELL + 1);

    logic [SELW-1:0] cur_q, cur_nxt;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic            prev_mode_q;
    logic [W-1:0]    out_q, out_d;
    logic [SELW-1:0] out_ch_q, out_ch_d;
    logic            out_valid_q, out_valid_d;
    logic            wrap_q, wrap_d;
    logic            err_q, err_d;

    logic [W-1:0]    ch_data_c [CH];
    logic [SELW-1:0] adv_c;
    logic            sel_ok_c;
    logic            accept_c;
    logic            capture_c;

    // Unpack the flat input bus into per-channel words
    for (genvar k = 0; k < CH; k++) begin : g_unpack
        assign ch_data_c[k] = in_i[k*W +: W];
    end

    // A select is only out of range when CH is not a power of two
    if (CH == (32'd1 << SELW)) begin : g_pow2
        assign sel_ok_c = 1'b1;
    end else begin : g_npow2
        assign sel_ok_c = (32'(sel_i) < CH);
    end

`ifdef MUX_SCAN_MASK_EN
    // Next enabled channel in cyclic order after cur; holds cur if the mask is empty
    always_comb begin
        int unsigned     idx;
        logic            found;
        logic [SELW-1:0] idx_s;
        adv_c = cur_q;
        found = 1'b0;
        idx   = 0;
        idx_s = '0;
        for (int unsigned i = 1; i <= CH; i++) begin
            idx = 32'(cur_q) + i;
            if (idx >= CH) begin
                idx = idx - CH;
            end
            idx_s = SELW'(idx);
            if (!found && ch_mask_i[idx_s]) begin
                adv_c = idx_s;
                found = 1'b1;
            end
        end
    end
`else
    // Next channel in cyclic order after cur
    always_comb begin
        adv_c = (cur_q == SELW'(CH - 1)) ? '0 : cur_q + SELW'(1);
    end
`endif

    assign accept_c  = out_valid_q & out_ready_i;
    assign capture_c = ~out_valid_q | out_ready_i;

    // Next-state: channel pointer, dwell counter, output sample and pulses
    always_comb begin
        cur_nxt     = cur_q;
        cnt_d       = cnt_q;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        wrap_d      = 1'b0;
        err_d       = ~mode_i & load_i & ~sel_ok_c;

        if (mode_i != prev_mode_q) begin
            cnt_d = '0;
        end else if (!mode_i) begin
            if (load_i && sel_ok_c) begin
                cur_nxt = sel_i;
            end
        end else if (accept_c) begin
            if (cnt_q == CNTW'(DWELL - 1)) begin
                cnt_d   = '0;
                cur_nxt = adv_c;
                wrap_d  = (adv_c < cur_q);
            end else begin
                cnt_d = cnt_q + CNTW'(1);
            end
        end

        if (capture_c) begin
            out_d       = ch_data_c[cur_nxt];
            out_ch_d    = cur_nxt;
            out_valid_d = 1'b1;
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cur_q       <= '0;
            cnt_q       <= '0;
            prev_mode_q <= 1'b0;
            out_q       <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            cur_q       <= cur_nxt;
            cnt_q       <= cnt_d;
            prev_mode_q <= mode_i;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
        end
    end

    assign out_o       = out_q;
    assign out_ch_o    = out_ch_q;
    assign out_valid_o = out_valid_q;
    assign wrap_o      = wrap_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// tb_mux_scan_n: directed + randomized checks of mux_scan_n against a behavioural model.

module tb_mux_scan_n;

    localparam int unsigned CH    = 8;
    localparam int unsigned W     = 4;
    localparam int unsigned DWELL = 2;
    localparam int unsigned SELW  = 3;
    localparam int unsigned CHB   = 6;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: CH=8, W=4, DWELL=2
    logic            a_rst, a_load, a_mode, a_ready;
    logic [CH*W-1:0] a_in;
    logic [SELW-1:0] a_sel;
    logic [W-1:0]    a_out;
    logic [SELW-1:0] a_ch;
    logic            a_valid, a_wrap, a_err;

    // Instance B: CH=6 (non power of two), DWELL=1
    logic             b_rst, b_load, b_mode, b_ready;
    logic [CHB*W-1:0] b_in;
    logic [SELW-1:0]  b_sel;
    logic [W-1:0]     b_out;
    logic [SELW-1:0]  b_ch;
    logic             b_valid, b_wrap, b_err;

`ifdef MUX_SCAN_MASK_EN
    logic [CH-1:0]  a_mask;
    logic [CHB-1:0] b_mask;
`endif

    mux_scan_n #(.CH(CH), .W(W), .DWELL(DWELL)) u_a (
        .clk_i       (clk),
        .rst_i       (a_rst),
        .in_i        (a_in),
        .sel_i       (a_sel),
        .load_i      (a_load),
        .mode_i      (a_mode),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask_i   (a_mask),
`endif
        .out_ready_i (a_ready),
        .out_o       (a_out),
        .out_ch_o    (a_ch),
        .out_valid_o (a_valid),
        .wrap_o      (a_wrap),
        .err_o       (a_err)
    );

    mux_scan_n #(.CH(CHB), .W(W), .DWELL(1)) u_b (
        .clk_i       (clk),
        .rst_i       (b_rst),
        .in_i        (b_in),
        .sel_i       (b_sel),
        .load_i      (b_load),
        .mode_i      (b_mode),
`ifdef MUX_SCAN_MASK_EN
        .ch_mask_i   (b_mask),
`endif
        .out_ready_i (b_ready),
        .out_o       (b_out),
        .out_ch_o    (b_ch),
        .out_valid_o (b_valid),
        .wrap_o      (b_wrap),
        .err_o       (b_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model of instance A: the scan position is derived from how many
    // samples the consumer has taken since scan mode was entered.
    logic         m_valid, m_wrap, m_pm;
    logic [W-1:0] m_out;
    int           m_ch, m_cur, m_base, m_nacc;

    function automatic logic [W-1:0] chan_a(int c);
        return W'(a_in >> (c * W));
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic acc, cap;
        int   nc;
        acc    = m_valid & a_ready;
        cap    = ~m_valid | a_ready;
        m_wrap = 1'b0;
        if (a_rst) begin
            m_cur = 0; m_ch = 0; m_out = '0; m_valid = 1'b0;
            m_pm = 1'b0; m_base = 0; m_nacc = 0;
        end else begin
            if (a_mode != m_pm) begin
                if (a_mode) begin
                    m_base = m_cur;
                    m_nacc = 0;
                end
            end else if (!a_mode) begin
                if (a_load) m_cur = int'(a_sel);
            end else if (acc) begin
                m_nacc++;
                if (m_nacc % DWELL == 0) begin
                    nc     = (m_base + m_nacc / DWELL) % CH;
                    m_wrap = (nc < m_cur);
                    m_cur  = nc;
                end
            end
            if (cap) begin
                m_out   = chan_a(m_cur);
                m_ch    = m_cur;
                m_valid = 1'b1;
            end
            m_pm = a_mode;
        end
    endtask

    task automatic check_a();
        chk("a_out",   32'(a_out),   32'(m_out));
        chk("a_ch",    32'(a_ch),    32'(m_ch));
        chk("a_valid", 32'(a_valid), 32'(m_valid));
        chk("a_wrap",  32'(a_wrap),  32'(m_wrap));
        chk("a_err",   32'(a_err),   32'd0);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_a();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
`ifdef MUX_SCAN_MASK_EN
        int exp_m [9] = '{0, 0, 2, 2, 5, 5, 7, 7, 0};
        a_mask = '1;
        b_mask = '1;
`endif
        a_rst = 1'b1; a_load = 1'b0; a_mode = 1'b0; a_ready = 1'b1; a_sel = '0;
        b_rst = 1'b1; b_load = 1'b0; b_mode = 1'b0; b_ready = 1'b1; b_sel = '0;
        for (int k = 0; k < CH; k++)  a_in[k*W +: W] = W'(k + 1);
        for (int k = 0; k < CHB; k++) b_in[k*W +: W] = W'(k + 1);

        // Reset held for three cycles
        for (int i = 0; i < 3; i++) step();
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_out",   32'(a_out),   32'd0);

        // First capture right after release
        a_rst = 1'b0;
        step();
        chk("first_out",   32'(a_out),   32'h1);
        chk("first_valid", 32'(a_valid), 32'd1);

        // Direct load of channel 5, then hold
        a_load = 1'b1; a_sel = 3'd5;
        step();
        chk("dir_out", 32'(a_out), 32'h6);
        chk("dir_ch",  32'(a_ch),  32'd5);
        a_load = 1'b0; a_sel = 3'd2;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("dir_hold", 32'(a_ch), 32'd5);
        end

        // Scan from reset: 0,0,1,1,...,7,7,0 with wrap on the 7->0 edge
        a_rst = 1'b1; a_mode = 1'b1;
        step();
        a_rst = 1'b0;
        for (int i = 0; i < 17; i++) begin
            step();
            chk("scan_seq",  32'(a_ch),   32'((i / 2) % 8));
            chk("scan_wrap", 32'(a_wrap), 32'(i == 16));
        end

        // Backpressure mid-dwell: output frozen while inputs change
        a_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a_in = 32'($urandom);
            step();
            chk("bp_out", 32'(a_out), 32'h1);
            chk("bp_ch",  32'(a_ch),  32'd0);
        end
        a_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("resume_ch", 32'(a_ch), 32'((j + 1) / 2));
        end

        // Randomized mixed traffic
        for (int i = 0; i < 600; i++) begin
            a_in    = 32'($urandom);
            a_ready = ($urandom_range(0, 3) != 0);
            a_load  = ($urandom_range(0, 2) == 0);
            a_sel   = SELW'($urandom);
            if ($urandom_range(0, 19) == 0) a_mode = ~a_mode;
            a_rst   = ($urandom_range(0, 99) == 0);
            step();
        end
        a_rst = 1'b0; a_load = 1'b0; a_ready = 1'b1;

        // Instance B: out-of-range load on a six-channel selector
        b_rst = 1'b0;
        step();
        chk("b_valid", 32'(b_valid), 32'd1);
        chk("b_ch0",   32'(b_ch),    32'd0);
        chk("b_out0",  32'(b_out),   32'h1);
        b_load = 1'b1; b_sel = 3'd7;
        step();
        chk("b_err_hi",   32'(b_err), 32'd1);
        chk("b_ch_keep",  32'(b_ch),  32'd0);
        b_load = 1'b0;
        step();
        chk("b_err_pulse", 32'(b_err), 32'd0);
        b_load = 1'b1; b_sel = 3'd3;
        step();
        chk("b_ch3",    32'(b_ch),  32'd3);
        chk("b_out3",   32'(b_out), 32'h4);
        chk("b_err_ok", 32'(b_err), 32'd0);
        b_sel = 3'd6;
        step();
        chk("b_err6",    32'(b_err),  32'd1);
        chk("b_ch_keep6", 32'(b_ch),  32'd3);
        chk("b_wrap",    32'(b_wrap), 32'd0);
        b_load = 1'b0;
        step();
        chk("b_err_clr", 32'(b_err), 32'd0);

`ifdef MUX_SCAN_MASK_EN
        // Masked scan: only channels 0,2,5,7
        a_rst = 1'b1; a_mode = 1'b1; a_mask = 8'b1010_0101;
        tick();
        a_rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("mask_seq",  32'(a_ch),   32'(exp_m[i]));
            chk("mask_wrap", 32'(a_wrap), 32'(i == 8));
        end
        a_mask = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mask0_ch",   32'(a_ch),   32'd0);
            chk("mask0_wrap", 32'(a_wrap), 32'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
